multicycle_controller: RTL and testbench

- Sequencing FSM that turns the single-cycle RISC-V datapath into a multicycle one. Instruction fetch and data access share one unified, variable-latency memory.
- Issues per-state mux selects and write enables to the PC, IR, register file, ALU and memory.
- Handles the memory ready handshake, evaluates branch conditions and traps on illegal opcodes or memory timeout.
- Sits beside the datapath at the CPU top level and replaces the combinational main decoder.

---
 rtl/multicycle_pkg.sv | 64 ++++++
 rtl/multicycle_controller_alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared state encoding, opcode constants and datapath select encodings
// for the multicycle RISC-V controller.
package multicycle_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_REG   = 2'b10;

    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Immediate format depends only on the opcode, so it is valid in every state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_SW:     return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus instruction fields to the
// ALU operation code.
module mc_alu_decoder
    import multicycle_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7_5_i,
    input  logic       op5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // Only R-type (opcode[5]=1) can encode sub; addi ignores bit 30.
                    3'b000:  alu_control_o = (op5_i & funct7_5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V sequencing FSM: per-state datapath selects and enables,
// memory ready handshake with timeout, branch resolution and trap handling.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RETIRE_W       = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic                funct7_5,
    input  logic                zero,
    input  logic                sign,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                MemWrite,
    output logic                AdrSrc,
    output logic                IRWrite,
    output logic                PCWrite,
    output logic                RegWrite,
    output logic [1:0]          ResultSrc,
    output logic [1:0]          ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          ImmSrc,
    output logic [2:0]          ALUControl,
    output logic                illegal,
    output logic                bus_error,
    output logic [RETIRE_W-1:0] instr_retired
);

    localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    state_t              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                illegal_q, illegal_d;
    logic                bus_error_q, bus_error_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;

    logic       mem_state;
    logic       timeout_hit;
    logic       take;
    logic [1:0] aluop;
    logic       mem_req_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c;

    assign mem_state = (state_q == FETCH) || (state_q == MEMREAD) || (state_q == MEMWRITE);

    // A ready arriving in the same cycle as the limit wins over the trap.
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && mem_state && !mem_ready &&
                         (wait_cnt_q == WAIT_W'(TIMEOUT_CYCLES));

    always_comb begin
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            3'b100:  take = sign;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        case (state_q)
            FETCH: begin
                if (mem_ready)        state_d = DECODE;
                else if (timeout_hit) state_d = TRAP;
            end
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECR;
                    OP_ITYPE:     state_d = EXECI;
                    OP_BRANCH:    state_d = BRANCH;
                    OP_JAL:       state_d = JAL;
                    default: begin
                        state_d   = TRAP;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            MEMADR:   state_d = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
            MEMREAD: begin
                if (mem_ready)        state_d = MEMWB;
                else if (timeout_hit) state_d = TRAP;
            end
            MEMWB:    state_d = FETCH;
            MEMWRITE: begin
                if (mem_ready)        state_d = FETCH;
                else if (timeout_hit) state_d = TRAP;
            end
            EXECR:    state_d = ALUWB;
            EXECI:    state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            BRANCH:   state_d = FETCH;
            JAL:      state_d = ALUWB;
            TRAP:     state_d = TRAP;
            default:  state_d = FETCH;
        endcase

        if (timeout_hit) bus_error_d = 1'b1;

        if (mem_state && !mem_ready && (state_d == state_q))
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        else
            wait_cnt_d = '0;

        // Every completed instruction ends with a return to FETCH.
        if ((state_d == FETCH) && (state_q != FETCH))
            retired_d = retired_q + RETIRE_W'(1);
        else
            retired_d = retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= FETCH;
            wait_cnt_q  <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
            retired_q   <= retired_d;
        end
    end

    always_comb begin
        mem_req_c   = 1'b0;
        mem_write_c = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_WDATA;
        aluop       = ALUOP_ADD;
        case (state_q)
            FETCH: begin
                mem_req_c  = 1'b1;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                ResultSrc  = RES_ALURESULT;
                ALUSrcB    = SRCB_FOUR;
            end
            DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            MEMADR: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
            end
            MEMREAD: begin
                mem_req_c = 1'b1;
                AdrSrc    = 1'b1;
            end
            MEMWB: begin
                ResultSrc   = RES_RDATA;
                reg_write_c = 1'b1;
            end
            MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                AdrSrc      = 1'b1;
            end
            EXECR: begin
                ALUSrcA = SRCA_REG;
                aluop   = ALUOP_FUNCT;
            end
            EXECI: begin
                ALUSrcA = SRCA_REG;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB:  reg_write_c = 1'b1;
            BRANCH: begin
                ALUSrcA    = SRCA_REG;
                aluop      = ALUOP_SUB;
                pc_write_c = take;
            end
            JAL: begin
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_write_c = 1'b1;
            end
            default: ;
        endcase
    end

    mc_alu_decoder u_alu_decoder (
        .aluop_i       (aluop),
        .funct3_i      (funct3),
        .funct7_5_i    (funct7_5),
        .op5_i         (opcode[5]),
        .alu_control_o (ALUControl)
    );

    // Enables are blanked while reset is held so an aborted access never commits.
    assign mem_req  = mem_req_c   & reset;
    assign MemWrite = mem_write_c & reset;
    assign IRWrite  = ir_write_c  & reset;
    assign PCWrite  = pc_write_c  & reset;
    assign RegWrite = reg_write_c & reset;

    assign ImmSrc        = imm_src_of(opcode);
    assign illegal       = illegal_q;
    assign bus_error     = bus_error_q;
    assign instr_retired = retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and randomized bench for multicycle_controller against a
// per-instruction phase-list reference model.
module tb_multicycle_controller;

    localparam int TO = 4;
    localparam int RW = 4;

    localparam int PH_F    = 0;
    localparam int PH_D    = 1;
    localparam int PH_MA   = 2;
    localparam int PH_MR   = 3;
    localparam int PH_MWB  = 4;
    localparam int PH_MW   = 5;
    localparam int PH_ER   = 6;
    localparam int PH_EI   = 7;
    localparam int PH_AWB  = 8;
    localparam int PH_BR   = 9;
    localparam int PH_JAL  = 10;
    localparam int PH_TRAP = 11;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] JL  = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    logic          clk, reset;
    logic [6:0]    opcode;
    logic [2:0]    funct3;
    logic          funct7_5, zero, sign, mem_ready;
    logic          mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
    logic [1:0]    ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0]    ALUControl;
    logic          illegal, bus_error;
    logic [RW-1:0] instr_retired;

    multicycle_controller #(.TIMEOUT_CYCLES(TO), .RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3),
        .funct7_5(funct7_5), .zero(zero), .sign(sign), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
        .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .illegal(illegal),
        .bus_error(bus_error), .instr_retired(instr_retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks, failures;
    int   m_retired;
    logic m_ill, m_bus;
    logic [6:0] m_op;
    logic [2:0] m_f3;
    logic m_f75, m_zero, m_sign;

    logic [18:0] obs_vec;
    assign obs_vec = {illegal, bus_error, mem_req, MemWrite, AdrSrc, IRWrite,
                      PCWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl};

    function automatic logic [2:0] ref_alu(input logic [6:0] op, input logic [2:0] f3, input logic f75);
        case (f3)
            3'b000:  return (op[5] && f75) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] ref_imm(input logic [6:0] op);
        if (op == SW) return 2'b01;
        if (op == BR) return 2'b10;
        if (op == JL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic ref_take(input logic [2:0] f3, input logic z, input logic s);
        return (f3 == 3'b000 && z) || (f3 == 3'b001 && !z) || (f3 == 3'b100 && s);
    endfunction

    function automatic logic [18:0] ref_vec(input int ph, input logic rdy);
        logic mreq, mw, adr, irw, pcw, rw;
        logic [1:0] rs, sa, sb;
        logic [2:0] ac;
        {mreq, mw, adr, irw, pcw, rw} = 6'b0;
        rs = 2'b00; sa = 2'b00; sb = 2'b00; ac = 3'b000;
        case (ph)
            PH_F:   begin mreq = 1; irw = rdy; pcw = rdy; rs = 2'b10; sb = 2'b10; end
            PH_D:   begin sa = 2'b01; sb = 2'b01; end
            PH_MA:  begin sa = 2'b10; sb = 2'b01; end
            PH_MR:  begin mreq = 1; adr = 1; end
            PH_MWB: begin rs = 2'b01; rw = 1; end
            PH_MW:  begin mreq = 1; mw = 1; adr = 1; end
            PH_ER:  begin sa = 2'b10; ac = ref_alu(m_op, m_f3, m_f75); end
            PH_EI:  begin sa = 2'b10; sb = 2'b01; ac = ref_alu(m_op, m_f3, m_f75); end
            PH_AWB: rw = 1;
            PH_BR:  begin sa = 2'b10; ac = 3'b001; pcw = ref_take(m_f3, m_zero, m_sign); end
            PH_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {m_ill, m_bus, mreq, mw, adr, irw, pcw, rw, rs, sa, sb, ref_imm(m_op), ac};
    endfunction

    function automatic string ph_name(input int ph);
        case (ph)
            PH_F: return "fetch";   PH_D: return "decode";  PH_MA: return "memadr";
            PH_MR: return "memread"; PH_MWB: return "memwb"; PH_MW: return "memwrite";
            PH_ER: return "execr";  PH_EI: return "execi";  PH_AWB: return "aluwb";
            PH_BR: return "branch"; PH_JAL: return "jal";   default: return "trap";
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int ph, input logic rdy);
        mem_ready = rdy;
        @(negedge clk);
        check(ph_name(ph), {13'd0, obs_vec}, {13'd0, ref_vec(ph, rdy)});
        @(posedge clk);
        #1;
    endtask

    task automatic mem_phase(input int ph, input int waits);
        for (int i = 0; i < waits; i++) cyc(ph, 1'b0);
        cyc(ph, 1'b1);
    endtask

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic z, input logic s);
        m_op = op; m_f3 = f3; m_f75 = f75; m_zero = z; m_sign = s;
        opcode = op; funct3 = f3; funct7_5 = f75; zero = z; sign = s;
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                             input logic z, input logic s, input int wf, input int wm);
        set_instr(op, f3, f75, z, s);
        mem_phase(PH_F, wf);
        cyc(PH_D, 1'($urandom_range(0, 1)));
        case (op)
            LW: begin
                cyc(PH_MA, 1'($urandom_range(0, 1)));
                mem_phase(PH_MR, wm);
                cyc(PH_MWB, 1'($urandom_range(0, 1)));
            end
            SW: begin
                cyc(PH_MA, 1'($urandom_range(0, 1)));
                mem_phase(PH_MW, wm);
            end
            RT: begin cyc(PH_ER, 1'($urandom_range(0, 1))); cyc(PH_AWB, 1'($urandom_range(0, 1))); end
            IT: begin cyc(PH_EI, 1'($urandom_range(0, 1))); cyc(PH_AWB, 1'($urandom_range(0, 1))); end
            BR: cyc(PH_BR, 1'($urandom_range(0, 1)));
            default: begin cyc(PH_JAL, 1'($urandom_range(0, 1))); cyc(PH_AWB, 1'($urandom_range(0, 1))); end
        endcase
        m_retired = (m_retired + 1) % (1 << RW);
        check("retired", {28'd0, instr_retired}, m_retired);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_enables", {27'd0, mem_req, MemWrite, IRWrite, PCWrite, RegWrite}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_retired = 0; m_ill = 1'b0; m_bus = 1'b0;
        check("rst_retired", {28'd0, instr_retired}, 32'd0);
        check("rst_flags", {30'd0, illegal, bus_error}, 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [6];
        checks = 0; failures = 0;
        m_retired = 0; m_ill = 1'b0; m_bus = 1'b0;
        reset = 1'b0; mem_ready = 1'b0;
        set_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0);
        ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT; ops[4] = BR; ops[5] = JL;

        do_reset();

        run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(RT, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, 3);
        run_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0, 1, 2);
        run_instr(BR, 3'b000, 1'b0, 1'b1, 1'b0, 0, 0);
        run_instr(BR, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(BR, 3'b100, 1'b0, 1'b0, 1'b1, 0, 0);
        run_instr(BR, 3'b101, 1'b0, 1'b1, 1'b1, 0, 0);
        run_instr(JL, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);
        run_instr(IT, 3'b000, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr(RT, 3'b111, 1'b0, 1'b0, 1'b0, 0, 0);

        // Illegal opcode traps and holds until reset
        set_instr(BAD, 3'b000, 1'b0, 1'b0, 1'b0);
        mem_phase(PH_F, 0);
        cyc(PH_D, 1'b1);
        m_ill = 1'b1;
        for (int i = 0; i < 20; i++) cyc(PH_TRAP, 1'($urandom_range(0, 1)));
        do_reset();

        // Fetch timeout: ready never arrives
        set_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < TO + 1; i++) cyc(PH_F, 1'b0);
        m_bus = 1'b1;
        for (int i = 0; i < 3; i++) cyc(PH_TRAP, 1'b1);
        do_reset();

        // Ready on the last allowed cycle wins over the trap
        run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, TO, 0);
        run_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0, 0, TO);

        // Read-phase timeout
        set_instr(LW, 3'b010, 1'b0, 1'b0, 1'b0);
        mem_phase(PH_F, 0);
        cyc(PH_D, 1'b0);
        cyc(PH_MA, 1'b0);
        for (int i = 0; i < TO + 1; i++) cyc(PH_MR, 1'b0);
        m_bus = 1'b1;
        cyc(PH_TRAP, 1'b0);
        do_reset();

        // Reset asserted mid-store
        run_instr(RT, 3'b110, 1'b0, 1'b0, 1'b0, 0, 0);
        set_instr(SW, 3'b010, 1'b0, 1'b0, 1'b0);
        mem_phase(PH_F, 0);
        cyc(PH_D, 1'b0);
        cyc(PH_MA, 1'b0);
        cyc(PH_MW, 1'b0);
        cyc(PH_MW, 1'b0);
        mem_ready = 1'b0;
        #1;
        check("mw_before_reset", {31'd0, MemWrite}, 32'd1);
        reset = 1'b0;
        #1;
        check("mw_during_reset", {30'd0, mem_req, MemWrite}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        m_retired = 0;
        check("mw_reset_retired", {28'd0, instr_retired}, 32'd0);
        run_instr(RT, 3'b000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Randomized instruction stream; long enough to wrap the retire counter
        for (int n = 0; n < 40; n++) begin
            run_instr(ops[$urandom_range(0, 5)], 3'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom),
                      $urandom_range(0, TO), $urandom_range(0, TO));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
